// File: rtl/spm_wb_ctrl.sv
// Wishbone slave front-end for the serial-parallel multiplier core: operand
// registers, start/done handshake with timeout, product and cycle-count capture.
module spm_wb_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] mc,
    output logic [31:0] mp,
    output logic        start,
    input  logic        done,
    input  logic [63:0] prod,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state;
    logic [63:0] prod_q;
    logic [15:0] cnt;
    logic [15:0] cycles_q;
    logic        done_q;
    logic        err_q;
    logic        ovr_q;
    logic        ie_q;

    logic [5:0]  ofs;
    logic        in_range;
    logic        accept;
    logic        wr;
    logic        ctrl_wr;
    logic        go;
    logic        clr;
    logic        busy;
    logic [15:0] cnt_inc;
    logic [31:0] rdata;
    logic        unused_adr;

    assign ofs        = wbs_adr_i[7:2];
    assign in_range   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign accept     = in_range & ~wbs_ack_o;
    assign wr         = accept & wbs_we_i;
    assign ctrl_wr    = wr & (ofs == 6'h02) & wbs_sel_i[0];
    assign go         = ctrl_wr & wbs_dat_i[0];
    assign clr        = ctrl_wr & wbs_dat_i[1];
    assign busy       = (state != S_IDLE);
    assign cnt_inc    = cnt + 16'd1;
    assign irq        = done_q & ie_q;
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        rdata = '0;
        case (ofs)
            6'h00:   rdata = mc;
            6'h01:   rdata = mp;
            6'h02:   rdata = {27'd0, ovr_q, err_q, ie_q, done_q, busy};
            6'h03:   rdata = prod_q[31:0];
            6'h04:   rdata = prod_q[63:32];
            6'h05:   rdata = {16'd0, cycles_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            mc        <= '0;
            mp        <= '0;
            start     <= 1'b0;
            prod_q    <= '0;
            cnt       <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
            start     <= 1'b0;

            // Operands are frozen while an operation is in flight.
            if (wr && !busy && ofs == 6'h00) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (wbs_sel_i[i]) mc[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
            if (wr && !busy && ofs == 6'h01) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (wbs_sel_i[i]) mp[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end

            if (ctrl_wr) ie_q <= wbs_dat_i[2];
            if (clr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (go && busy) ovr_q <= 1'b1;

            // Hardware flag sets below come after the clear so they win.
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_LAUNCH;
                        start <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        prod_q   <= prod;
                        cycles_q <= cnt_inc;
                        done_q   <= 1'b1;
                        state    <= S_IDLE;
                    end else if (cnt_inc == TIMEOUT_W) begin
                        cycles_q <= TIMEOUT_W;
                        err_q    <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_wb_ctrl.sv
// Bench for spm_wb_ctrl: directed and randomized operations against a
// register-level reference model and a variable-latency multiplier model.
module tb_spm_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] mc, mp;
    logic        start;
    logic        done;
    logic [63:0] prod;
    logic        irq;

    spm_wb_ctrl #(.BASE_ADR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .mc(mc), .mp(mp), .start(start), .done(done), .prod(prod), .irq(irq)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Multiplier core model: done rises core_lat cycles after start (0 = never).
    int          core_lat = 0;
    int          ticks = 0;
    bit          run = 0;
    logic        core_done = 1'b0;
    logic [63:0] core_p = '0;
    assign done = core_done;
    assign prod = core_p;

    always @(posedge clk) begin
        if (start) begin
            core_p    <= {32'd0, mc} * {32'd0, mp};
            ticks     <= 1;
            run       <= (core_lat != 1);
            core_done <= (core_lat == 1);
        end else if (run) begin
            ticks <= ticks + 1;
            if (ticks + 1 == core_lat) begin
                core_done <= 1'b1;
                run       <= 0;
            end
        end
    end

    int cyc_n = 0;
    int start_cnt = 0;
    int s_cyc = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (start === 1'b1) begin
        start_cnt++;
        s_cyc = cyc_n;
    end

    // Reference register state
    logic [31:0] m_mc, m_mp;
    logic        m_ie, m_done, m_err, m_ovr;
    logic [63:0] m_prod;
    logic [15:0] m_cyc;

    task automatic mdl_reset();
        m_mc = '0; m_mp = '0; m_ie = 0; m_done = 0; m_err = 0; m_ovr = 0;
        m_prod = '0; m_cyc = '0;
    endtask

    task automatic mdl_write(input logic [7:0] ofs, input logic [31:0] d,
                             input logic [3:0] sel, input bit busy);
        case (ofs)
            8'h00: if (!busy) for (int i = 0; i < 4; i++) if (sel[i]) m_mc[8*i +: 8] = d[8*i +: 8];
            8'h04: if (!busy) for (int i = 0; i < 4; i++) if (sel[i]) m_mp[8*i +: 8] = d[8*i +: 8];
            8'h08: if (sel[0]) begin
                m_ie = d[2];
                if (d[1]) begin m_done = 0; m_err = 0; m_ovr = 0; end
                if (d[0] && busy) m_ovr = 1;
            end
            default: ;
        endcase
    endtask

    // Bus tasks are entered and left 1 time unit after a rising edge.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rd, output bit acked);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = d; wbs_sel_i = sel;
        acked = 0; rd = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin acked = 1; rd = wbs_dat_o; end
        end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    endtask

    task automatic wb_wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] rd;
        bit ak;
        bus(1'b1, BASE + {24'd0, ofs}, d, sel, rd, ak);
        chk("wr_ack", 64'(ak), 1);
    endtask

    task automatic wb_rd(input logic [7:0] ofs, output logic [31:0] d);
        bit ak;
        bus(1'b0, BASE + {24'd0, ofs}, '0, 4'hF, d, ak);
        chk("rd_ack", 64'(ak), 1);
    endtask

    task automatic wait_cycle(input int t);
        for (int i = 0; i < 100000 && cyc_n < t; i++) begin @(posedge clk); #1; end
    endtask

    task automatic read_all(input string tag);
        logic [31:0] d;
        wb_rd(8'h00, d); chk({tag, ".MC"}, d, m_mc);
        wb_rd(8'h04, d); chk({tag, ".MP"}, d, m_mp);
        wb_rd(8'h08, d); chk({tag, ".CTRL"}, d, {27'd0, m_ovr, m_err, m_ie, m_done, 1'b0});
        wb_rd(8'h0C, d); chk({tag, ".PROD_LO"}, d, m_prod[31:0]);
        wb_rd(8'h10, d); chk({tag, ".PROD_HI"}, d, m_prod[63:32]);
        wb_rd(8'h14, d); chk({tag, ".CYCLES"}, d, {16'd0, m_cyc});
        chk({tag, ".irq"}, 64'(irq), 64'(m_done & m_ie));
        chk({tag, ".mc_pin"}, mc, m_mc);
        chk({tag, ".mp_pin"}, mp, m_mp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sa, input logic [3:0] sb, input int l,
                          input logic ie, input logic clr, input logic [31:0] mid_ctrl,
                          input int probe, input bit clr_at_done);
        int sc0, s, eff, fin;
        logic [31:0] d, op_mc, op_mp;
        logic [31:0] c;
        wb_wr(8'h00, a, sa); mdl_write(8'h00, a, sa, 0);
        wb_wr(8'h04, b, sb); mdl_write(8'h04, b, sb, 0);
        core_lat = l;
        sc0 = start_cnt;
        c = {29'd0, ie, clr, 1'b1};
        wb_wr(8'h08, c, 4'h1); mdl_write(8'h08, c, 4'h1, 0);
        for (int i = 0; i < 4 && start_cnt == sc0; i++) begin @(posedge clk); #1; end
        s = (start_cnt == sc0) ? cyc_n - 1 : s_cyc;
        eff = (l >= 1 && l <= TMO) ? l : TMO;
        fin = s + eff;
        op_mc = m_mc; op_mp = m_mp;
        if (mid_ctrl != 0) begin
            wb_wr(8'h00, 32'd7, 4'hF); mdl_write(8'h00, 32'd7, 4'hF, 1);
            wb_wr(8'h08, mid_ctrl, 4'h1); mdl_write(8'h08, mid_ctrl, 4'h1, 1);
            wb_rd(8'h00, d); chk({tag, ".MC_busy"}, d, m_mc);
            chk({tag, ".mc_hold"}, mc, op_mc);
        end
        if (probe > 0) begin
            wait_cycle(s + probe);
            wb_rd(8'h08, d);
            chk({tag, ".busy_probe"}, 64'(d[0]), 64'(probe <= eff));
        end
        if (clr_at_done) begin
            wait_cycle(fin);
            c = {29'd0, m_ie, 1'b1, 1'b0};
            wb_wr(8'h08, c, 4'h1); mdl_write(8'h08, c, 4'h1, 1);
        end
        wait_cycle(fin + 1);
        if (l >= 1 && l <= TMO) begin
            m_prod = {32'd0, op_mc} * {32'd0, op_mp};
            m_cyc  = 16'(l);
            m_done = 1;
        end else begin
            m_err = 1;
            m_cyc = 16'(TMO);
        end
        read_all(tag);
        chk({tag, ".start_pulses"}, 64'(start_cnt - sc0), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit ak;
        int sc0, l, pick, eff;
        logic [31:0] mid;

        rst = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        mdl_reset();
        chk("rst.ack", 64'(wbs_ack_o), 0);
        chk("rst.dat", wbs_dat_o, 0);
        chk("rst.start", 64'(start), 0);
        read_all("reset");
        chk("reset.no_start", 64'(start_cnt), 0);

        run_op("basic", 32'd3, 32'd5, 4'hF, 4'hF, 64, 1'b1, 1'b0, 32'd0, 0, 0);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 4'hF, 40, 1'b1, 1'b0, 32'h5, 0, 0);
        wb_wr(8'h08, 32'h2, 4'h1); mdl_write(8'h08, 32'h2, 4'h1, 0);
        read_all("clr");

        run_op("tmo_never", 32'h1234, 32'h5678, 4'hF, 4'hF, 0, 1'b0, 1'b0, 32'd0, 256, 0);
        run_op("tmo_late", 32'hABCD, 32'h11, 4'hF, 4'h3, 300, 1'b1, 1'b1, 32'd0, 257, 0);
        run_op("at_tmo", 32'h9, 32'hA, 4'h1, 4'h1, 256, 1'b1, 1'b1, 32'd0, 0, 0);
        run_op("lat1", 32'hDEAD_BEEF, 32'h2, 4'hF, 4'hF, 1, 1'b0, 1'b1, 32'd0, 0, 0);
        run_op("set_vs_clr", 32'h100, 32'h100, 4'hF, 4'hF, 30, 1'b1, 1'b1, 32'd0, 0, 1);

        // Reset in the middle of an operation
        wb_wr(8'h00, 32'h55, 4'hF); mdl_write(8'h00, 32'h55, 4'hF, 0);
        core_lat = 100;
        sc0 = start_cnt;
        wb_wr(8'h08, 32'h5, 4'h1);
        wait_cycle(cyc_n + 20);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mdl_reset();
        chk("rst_mid.mc", mc, 0);
        chk("rst_mid.start", 64'(start), 0);
        wait_cycle(cyc_n + 120);
        chk("rst_mid.start_pulses", 64'(start_cnt - sc0), 1);
        read_all("rst_mid");

        bus(1'b0, BASE + 32'h100, '0, 4'hF, d, ak);
        chk("oor.ack", 64'(ak), 0);
        wb_wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        wb_rd(8'h20, d);
        chk("hole.rd", d, 0);
        read_all("hole");

        for (int k = 0; k < 10; k++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: l = 1;
                1: l = 2;
                2: l = 255;
                3: l = 256;
                4: l = 257;
                5: l = 0;
                default: l = $urandom_range(3, 300);
            endcase
            eff = (l >= 1 && l <= TMO) ? l : TMO;
            mid = '0;
            if (eff >= 8 && $urandom_range(0, 1) == 1) mid = {29'd0, 3'($urandom_range(0, 7))} | 32'h1;
            run_op("rand", $urandom, $urandom, 4'($urandom), 4'($urandom), l,
                   1'($urandom), 1'($urandom), mid, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spm_wb_ctrl.md
# spm_wb_ctrl

Wishbone slave front-end that feeds the serial-parallel multiplier (SPM) core from the management SoC instead of the logic analyzer. It holds the multiplicand/multiplier operand registers, issues a one-cycle `start` to the core, waits for `done` with a timeout, latches the 64-bit product and the operation cycle count, and exposes control, status and results through a 32-bit register map. It sits between the wrapper's Wishbone slave port and the multiplier's `mc`/`mp`/`start`/`done`/`prod` pins.

## Interface
Parameters:
- `BASE_ADR`, default 32'h3000_0000: decode base; only `wbs_adr_i[31:8]` is compared against `BASE_ADR[31:8]`.
- `TIMEOUT`, default 256: maximum number of cycles from `start` to `done` before the operation is aborted. Legal range is 2..65535.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; shared with the multiplier core.
- `rst`  in  1  synchronous active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  read data.
- `mc`  out  32  multiplicand to the core.
- `mp`  out  32  multiplier to the core.
- `start`  out  1  one-cycle start pulse to the core.
- `done`  in  1  core completion, treated as a level.
- `prod`  in  64  core product.
- `irq`  out  1  level interrupt, equal to `DONE & IE`.

## Operation
- Register map (word offset is `adr[7:2]`):
  - 0x00 `MC`: RW, byte-writable.
  - 0x04 `MP`: RW, byte-writable.
  - 0x08 `CTRL`, write bits:
    - bit0 `GO`: start an operation when idle.
    - bit1 `CLR`: clear `DONE`, `ERR` and `OVR`.
    - bit2 `IE`: interrupt enable, stored.
  - 0x08 `CTRL`, read bits:
    - bit0 `BUSY`
    - bit1 `DONE`
    - bit2 `IE`
    - bit3 `ERR` (timeout)
    - bit4 `OVR` (`GO` issued while busy)
  - 0x0C `PROD_LO`: RO.
  - 0x10 `PROD_HI`: RO.
  - 0x14 `CYCLES`: RO, 16-bit value, zero-extended.
  - Other offsets inside the block: writes are ignored, reads return 0, and the access is still acked.
- Decode and acknowledge:
  - An access is in range when `stb & cyc` and `adr[31:8] == BASE_ADR[31:8]`.
  - Out-of-range accesses are never acked, because another slave answers them.
  - `wbs_dat_o` is 0 whenever `wbs_ack_o` is 0.
- Finite state machine (FSM): `IDLE` → `LAUNCH` → `WAIT` → `IDLE`.
  - `IDLE`: a `CTRL` write with `GO`=1 goes to `LAUNCH`. The same write's `CLR` is applied first, so the status is clean for the new operation.
  - `LAUNCH`: `start`=1 for exactly this one cycle, and the cycle counter is cleared. Next state is `WAIT`.
  - `WAIT`, when `done` is sampled high:
    - `prod` is captured into `PROD_LO`/`PROD_HI`.
    - The counter value is captured into `CYCLES`.
    - `DONE` is set and the FSM returns to `IDLE`.
  - `WAIT`, when the counter reaches `TIMEOUT` with `done` still low:
    - `ERR` is set, `CYCLES` is set to `TIMEOUT`, and `PROD` is unchanged.
    - `DONE` stays 0 and the FSM returns to `IDLE`.
- While `BUSY` (`LAUNCH`/`WAIT`):
  - Writes to `MC`/`MP` are ignored, so `mc`/`mp` are stable for the whole operation.
  - A `GO` write sets `OVR` and does not restart the operation; its `CLR` and `IE` bits are still applied.
- `done` is ignored in `IDLE` and `LAUNCH`. This handles a level left high from the previous operation.
- Flag precedence: if a hardware set and a `CLR` land in the same cycle, the set wins (`DONE`/`ERR` end up 1).
- Cycle counter: 16 bits. It counts `WAIT` cycles, so with `start` in cycle S and `done` first high in cycle D, `CYCLES` = D − S. It cannot wrap because `TIMEOUT` ≤ 65535.

## Timing
- Reset values:
  - All registers are 0 and the FSM is in `IDLE`.
  - Outputs: `wbs_ack_o`=0, `wbs_dat_o`=0, `mc`=0, `mp`=0, `start`=0, `irq`=0.
- A reset mid-operation aborts immediately: there is no capture, and `start` is not reissued.
- Acknowledge timing: a request is accepted in cycle N when `stb & cyc & ~ack`, and `wbs_ack_o`=1 in cycle N+1 only. Back-to-back requests therefore complete at most one every 2 cycles.
- A `CTRL` write with `GO` accepted in cycle N gives `start`=1 in cycle N+1 and the FSM in `WAIT` from N+2.
- Register visibility:
  - Register writes take effect at the end of cycle N.
  - `mc`/`mp` are valid from cycle N+1, before `start`.
  - Read data is registered, valid with ack, and reflects state at the end of cycle N.
- `done` sampled high in cycle D gives `DONE`/`PROD`/`irq` updated in cycle D+1 and `BUSY`=0 in cycle D+1.
- Unselected byte lanes keep their previous value. `CTRL` writes ignore `wbs_sel_i[3:1]`.

## Test plan
- Reset, then read 0x00, 0x08, 0x0C, 0x10 and 0x14 → all return 0; `start`=0 and `irq`=0 throughout.
- Write `MC`=32'h0000_0003, `MP`=32'h0000_0005, `CTRL`=32'h5; the core model has 64-cycle latency → exactly one `start` pulse, `CYCLES`=64, `PROD_LO`=15, `PROD_HI`=0, `CTRL` read = 32'h6, `irq`=1.
- `MC`=`MP`=32'hFFFF_FFFF → `PROD_HI`=32'hFFFF_FFFE, `PROD_LO`=32'h0000_0001. A write of `MC`=7 during `WAIT` leaves `mc` at 32'hFFFF_FFFF and `MC` reads back 32'hFFFF_FFFF.
- `GO` while `BUSY` → no second `start`, `OVR`=1. A later `CTRL`=32'h2 clears `OVR` and `DONE`.
- Core model never asserts `done`, `TIMEOUT`=256 → `ERR`=1, `DONE`=0, `CYCLES`=256, `PROD` unchanged, `BUSY`=0 at cycle S+257.
- `rst` pulsed in the middle of `WAIT` → no capture and all registers read 0. A read at address `BASE_ADR`+32'h100 (out of range) → no ack; `BASE_ADR`+32'h20 → acked, reads 0.
